cpu_run_ctrl: RTL and testbench

//  Run/halt/single-step sequencer for the Pipeline core. Replaces the free-running ClockDIV toggle.

---
 rtl/cpu_run_ctrl.sv | 139 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer: issues one-cycle CPU clock-enables on CLOCK.
// Optional PC breakpoint support is compiled in when BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned DIV        = 2,
  parameter int unsigned RST_HOLD   = 4,
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Step,
  input  logic [31:0] PC,
  input  logic [31:0] BrkAddr,
  input  logic        BrkEn,
  output logic        CpuEn,
  output logic        CpuReset,
  output logic [3:0]  Estado,
  output logic [31:0] CycleCount
);

  localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(DIV - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [DebW-1:0]  DebMax   = DebW'(DEB_CYCLES);

  typedef enum logic [3:0] {
    StRst   = 4'd0,
    StHalt  = 4'd1,
    StRun   = 4'd2,
    StStep  = 4'd3,
    StBreak = 4'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [DebW-1:0]   deb_q, deb_d;
  logic              press_q, press_d;
  logic              en_q, en_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              tick_due;
  logic              brk_hit;

`ifdef BREAKPOINT_EN
  assign brk_hit = BrkEn && (PC == BrkAddr);
`else
  logic unused_brk;
  assign unused_brk = ^{PC, BrkAddr, BrkEn};
  assign brk_hit    = 1'b0;
`endif

  // Counter saturates at DebMax so a held button yields a single press.
  always_comb begin
    deb_d   = '0;
    press_d = 1'b0;
    if (Step) begin
      deb_d   = (deb_q == DebMax) ? deb_q : deb_q + DebW'(1);
      press_d = (deb_q == DebLast);
    end
  end

  assign tick_due = ((state_q == StRun) || (state_q == StStep)) && (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    en_d    = 1'b0;
    case (state_q)
      StRst: begin
        if (hold_q == HoldLast) state_d = StHalt;
        else                    hold_d  = hold_q + HoldW'(1);
      end
      StHalt: begin
        if (Run)          state_d = StRun;
        else if (press_q) state_d = StStep;
      end
      StRun: begin
        if (tick_due && brk_hit) begin
          state_d = StBreak;
        end else begin
          en_d = tick_due;
          if (!Run) state_d = StHalt;
        end
      end
      StStep: begin
        if (tick_due) begin
          en_d    = 1'b1;
          state_d = StHalt;
        end
      end
      StBreak: begin
        if (!Run)         state_d = StHalt;
        else if (press_q) state_d = StStep;
      end
      default: state_d = StRst;
    endcase
  end

  // Divider restarts on every state change so STEP/RUN ticks land DIV cycles after entry.
  always_comb begin
    div_d = '0;
    if ((state_d == state_q) && !tick_due &&
        ((state_q == StRun) || (state_q == StStep))) begin
      div_d = div_q + DivW'(1);
    end
  end

  assign cycle_d = cycle_q + 32'(en_d);

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state_q <= StRst;
      div_q   <= '0;
      hold_q  <= '0;
      deb_q   <= '0;
      press_q <= 1'b0;
      en_q    <= 1'b0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      en_q    <= en_d;
      cycle_q <= cycle_d;
    end
  end

  assign CpuEn      = en_q;
  assign CpuReset   = (state_q == StRst);
  assign Estado     = state_q;
  assign CycleCount = cycle_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: vector table plus hand sequences for reset,
// run, breakpoint, counter wrap and mid-run reset.
module tb_cpu_run_ctrl;

  logic        CLOCK = 1'b0;
  logic        Reset, Run, Step, BrkEn;
  logic [31:0] PC, BrkAddr;
  logic        CpuEn, CpuReset;
  logic [3:0]  Estado;
  logic [31:0] CycleCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        run;
    logic        step;
    logic [3:0]  est;
    logic        en;
    logic [31:0] cc;
  } vec_t;

  vec_t vecs[$];

  cpu_run_ctrl #(
    .DIV        (2),
    .RST_HOLD   (4),
    .DEB_CYCLES (3)
  ) dut (
    .CLOCK      (CLOCK),
    .Reset      (Reset),
    .Run        (Run),
    .Step       (Step),
    .PC         (PC),
    .BrkAddr    (BrkAddr),
    .BrkEn      (BrkEn),
    .CpuEn      (CpuEn),
    .CpuReset   (CpuReset),
    .Estado     (Estado),
    .CycleCount (CycleCount)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input logic [3:0] est, input logic en,
                             input logic [31:0] cc);
    check({name, ".Estado"}, 32'(Estado), 32'(est));
    check({name, ".CpuEn"}, 32'(CpuEn), 32'(en));
    check({name, ".CycleCount"}, CycleCount, cc);
  endtask

  task automatic clk1;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic add(input logic r, input logic s, input logic [3:0] e, input logic n,
                     input logic [31:0] c);
    vec_t v;
    v.run  = r;
    v.step = s;
    v.est  = e;
    v.en   = n;
    v.cc   = c;
    vecs.push_back(v);
  endtask

  // Release reset and expect RST_HOLD cycles of CpuReset before HALT.
  task automatic rst_release(input string name);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({name, ".hold_cpureset"}, 32'(CpuReset), 32'd1);
      check({name, ".hold_estado"}, 32'(Estado), 32'd0);
      clk1();
    end
    check({name, ".released_cpureset"}, 32'(CpuReset), 32'd0);
    check_state({name, ".halt"}, 4'd1, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    logic        exp_en;
    logic [3:0]  exp_est;

    Run = 1'b0; Step = 1'b0; PC = '0; BrkAddr = 32'h0000_000C; BrkEn = 1'b0;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    repeat (3) clk1();
    check("in_reset.CpuReset", 32'(CpuReset), 32'd1);
    check_state("in_reset", 4'd0, 1'b0, 32'd0);
    rst_release("por");

    // run, step, expected Estado, CpuEn, CycleCount after the next edge
    add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0); add(0, 0, 1, 0, 0);           // short bounce
    add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0);           // press registers
    add(0, 1, 3, 0, 0); add(0, 1, 3, 0, 0); add(0, 0, 1, 1, 1);           // one step tick
    add(0, 0, 1, 0, 1);
    add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1);           // press pending
    add(1, 0, 2, 0, 1); add(1, 0, 2, 0, 1); add(1, 0, 2, 1, 2);           // Run beats press
    add(1, 1, 2, 0, 2); add(1, 1, 2, 1, 3); add(1, 1, 2, 0, 3);           // press in RUN
    add(1, 1, 2, 1, 4); add(0, 0, 1, 0, 4); add(0, 0, 1, 0, 4);           // ignored
    add(1, 0, 2, 0, 4); add(1, 0, 2, 0, 4); add(0, 0, 1, 1, 5);           // due tick on Run=0
    add(0, 0, 1, 0, 5);
    add(0, 1, 1, 0, 5); add(0, 1, 1, 0, 5); add(0, 1, 1, 0, 5);
    add(0, 0, 3, 0, 5); add(1, 0, 3, 0, 5); add(1, 0, 1, 1, 6);           // Run ignored in STEP
    add(0, 0, 1, 0, 6);

    foreach (vecs[k]) begin
      Run  = vecs[k].run;
      Step = vecs[k].step;
      clk1();
      check_state($sformatf("vec%0d", k), vecs[k].est, vecs[k].en, vecs[k].cc);
    end

    // Free run: Run high for 20 edges, then low on the edge where a tick is due.
    for (int i = 0; i <= 20; i++) begin
      Run = (i < 20);
      clk1();
      check($sformatf("run20.cpuen%0d", i), 32'(CpuEn), 32'((i >= 2) && (i % 2 == 0)));
    end
    Run = 1'b0;
    check_state("run20.end", 4'd1, 1'b1, 32'd16);

    // Breakpoint at 0xC with the PC advancing 4 per CpuEn.
    BrkEn = 1'b1;
    pc = '0;
    PC = pc;
    Run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      clk1();
`ifdef BREAKPOINT_EN
      exp_en  = (i == 2) || (i == 4) || (i == 6);
      exp_est = (i >= 8) ? 4'd4 : 4'd2;
`else
      exp_en  = (i >= 2) && (i % 2 == 0);
      exp_est = 4'd2;
`endif
      check($sformatf("brk.cpuen%0d", i), 32'(CpuEn), 32'(exp_en));
      check($sformatf("brk.estado%0d", i), 32'(Estado), 32'(exp_est));
      if (exp_en) pc = pc + 32'd4;
      PC = pc;
    end
`ifdef BREAKPOINT_EN
    check("brk.count", CycleCount, 32'd19);
    Step = 1'b1;
    repeat (3) begin
      clk1();
      check_state("brk.press", 4'd4, 1'b0, 32'd19);
    end
    Step = 1'b0;
    clk1();
    check_state("brk.step_entry", 4'd3, 1'b0, 32'd19);
    clk1();
    check_state("brk.step_wait", 4'd3, 1'b0, 32'd19);
    clk1();
    check_state("brk.step_tick", 4'd1, 1'b1, 32'd20);
    Run = 1'b0;
    clk1();
    check_state("brk.halt", 4'd1, 1'b0, 32'd20);
`else
    check("brk.count", CycleCount, 32'd21);
    Run = 1'b0;
    clk1();
    check_state("brk.ignored_stop", 4'd1, 1'b1, 32'd22);
    clk1();
    check_state("brk.halt", 4'd1, 1'b0, 32'd22);
`endif
    BrkEn = 1'b0;

    // Counter wrap: preload near all-ones, then run two ticks.
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    Run = 1'b1;
    clk1();
    clk1();
    clk1();
    check_state("wrap.ones", 4'd2, 1'b1, 32'hFFFF_FFFF);
    clk1();
    clk1();
    check_state("wrap.zero", 4'd2, 1'b1, 32'd0);
    Run = 1'b0;
    clk1();
    check_state("wrap.halt", 4'd1, 1'b0, 32'd0);

    // Asynchronous reset while a CpuEn pulse is active; Run stays high through RST.
    Run = 1'b1;
    clk1();
    clk1();
    clk1();
    check_state("midrst.pre", 4'd2, 1'b1, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("midrst.cpureset", 32'(CpuReset), 32'd1);
    check_state("midrst.abort", 4'd0, 1'b0, 32'd0);
    clk1();
    clk1();
    rst_release("midrst");
    Run = 1'b0;
    clk1();
    check_state("midrst.halt", 4'd1, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
